// File: rtl/audio_xfade_selector_pkg.sv
// Shared types and constants for the stereo source selector / crossfader.
package audio_xfade_selector_pkg;

   localparam int AUDIO_W = 24;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FADE = 1'b1
   } xfade_state_t;

endpackage

// File: rtl/audio_xfade_selector_mac.sv
// One-channel weighted mix: (a*(2^RAMP_SHIFT-k) + b*k) >>> RAMP_SHIFT, purely combinational.
module audio_xfade_selector_mac
   import audio_xfade_selector_pkg::*;
#(
   parameter int WIDTH      = AUDIO_W,
   parameter int RAMP_SHIFT = 8
) (
   input  logic [WIDTH-1:0]    i_a,
   input  logic [WIDTH-1:0]    i_b,
   input  logic [RAMP_SHIFT:0] i_k,
   output logic [WIDTH-1:0]    o_y
);

   localparam int SUM_W = WIDTH + RAMP_SHIFT + 2;
   localparam logic signed [SUM_W-1:0] W_FULL = SUM_W'(1) << RAMP_SHIFT;

   logic signed [SUM_W-1:0] w_a;
   logic signed [SUM_W-1:0] w_b;
   logic signed [SUM_W-1:0] w_wa;
   logic signed [SUM_W-1:0] w_wb;
   logic signed [SUM_W-1:0] w_sum;

   assign w_a   = SUM_W'($signed(i_a));
   assign w_b   = SUM_W'($signed(i_b));
   assign w_wb  = SUM_W'(i_k);
   assign w_wa  = W_FULL - w_wb;
   assign w_sum = (w_a * w_wa) + (w_b * w_wb);

   // Weights sum to 2^RAMP_SHIFT, so the floored quotient always fits WIDTH bits.
   assign o_y = WIDTH'(w_sum >>> RAMP_SHIFT);

endmodule

// File: rtl/audio_xfade_selector.sv
// Stereo NUM_SRC:1 source selector with click-free linear crossfade, stepped by the codec sample strobe.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | output follows src[cur_src]; watch sel for a new valid source
//   ST_FADE | k ramps 1..2^RAMP_SHIFT, output blends cur_src toward tgt_src
module audio_xfade_selector
   import audio_xfade_selector_pkg::*;
#(
   parameter int WIDTH      = AUDIO_W,
   parameter int NUM_SRC    = 4,
   parameter int RAMP_SHIFT = 8,
   parameter int SEL_W      = $clog2(NUM_SRC)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     sample_valid,
   input  logic [NUM_SRC*WIDTH-1:0] src_left,
   input  logic [NUM_SRC*WIDTH-1:0] src_right,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     fade_bypass,
   output logic [WIDTH-1:0]         out_left,
   output logic [WIDTH-1:0]         out_right,
   output logic                     out_valid,
   output logic                     fading
);

   localparam int NSEL = 2 ** SEL_W;
   localparam int KW   = RAMP_SHIFT + 1;
   localparam logic [KW-1:0] K_FULL = KW'(1) << RAMP_SHIFT;

   xfade_state_t     r_state;
   logic [SEL_W-1:0] r_cur;
   logic [SEL_W-1:0] r_tgt;
   logic [KW-1:0]    r_k;
   logic [WIDTH-1:0] r_out_l;
   logic [WIDTH-1:0] r_out_r;
   logic             r_out_valid;
   logic             r_fading;

   logic [WIDTH-1:0] w_src_l [NSEL];
   logic [WIDTH-1:0] w_src_r [NSEL];
   logic [WIDTH-1:0] w_mix_l;
   logic [WIDTH-1:0] w_mix_r;
   logic [KW-1:0]    w_k_next;
   logic             w_sel_ok;
   logic             w_sel_new;

   // Unused select codes (non-power-of-2 NUM_SRC) map to zero and are never chosen.
   for (genvar g = 0; g < NSEL; g++) begin : g_demux
      if (g < NUM_SRC) begin : g_src
         assign w_src_l[g] = src_left[g*WIDTH +: WIDTH];
         assign w_src_r[g] = src_right[g*WIDTH +: WIDTH];
      end else begin : g_pad
         assign w_src_l[g] = '0;
         assign w_src_r[g] = '0;
      end
   end

   assign w_sel_ok  = ({1'b0, sel} < (SEL_W+1)'(NUM_SRC));
   assign w_sel_new = w_sel_ok && (sel != r_cur);
   assign w_k_next  = r_k + KW'(1);

   audio_xfade_selector_mac #(.WIDTH(WIDTH), .RAMP_SHIFT(RAMP_SHIFT)) u_mac_l (
      .i_a (w_src_l[r_cur]),
      .i_b (w_src_l[r_tgt]),
      .i_k (w_k_next),
      .o_y (w_mix_l)
   );

   audio_xfade_selector_mac #(.WIDTH(WIDTH), .RAMP_SHIFT(RAMP_SHIFT)) u_mac_r (
      .i_a (w_src_r[r_cur]),
      .i_b (w_src_r[r_tgt]),
      .i_k (w_k_next),
      .o_y (w_mix_r)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_cur       <= '0;
         r_tgt       <= '0;
         r_k         <= '0;
         r_out_l     <= '0;
         r_out_r     <= '0;
         r_out_valid <= 1'b0;
         r_fading    <= 1'b0;
      end else begin
         r_out_valid <= sample_valid;
         if (sample_valid) begin
            r_fading <= (r_state == ST_FADE);
            case (r_state)
               ST_IDLE: begin
                  if (w_sel_new && fade_bypass) begin
                     r_cur   <= sel;
                     r_out_l <= w_src_l[sel];
                     r_out_r <= w_src_r[sel];
                  end else begin
                     r_out_l <= w_src_l[r_cur];
                     r_out_r <= w_src_r[r_cur];
                     if (w_sel_new) begin
                        r_tgt   <= sel;
                        r_k     <= '0;
                        r_state <= ST_FADE;
                     end
                  end
               end
               ST_FADE: begin
                  if (fade_bypass) begin
                     r_out_l <= w_src_l[r_tgt];
                     r_out_r <= w_src_r[r_tgt];
                     r_cur   <= r_tgt;
                     r_k     <= '0;
                     r_state <= ST_IDLE;
                  end else begin
                     // At k = 2^RAMP_SHIFT the mix is exactly the target sample.
                     r_out_l <= w_mix_l;
                     r_out_r <= w_mix_r;
                     r_k     <= w_k_next;
                     if (w_k_next == K_FULL) begin
                        r_cur   <= r_tgt;
                        r_state <= ST_IDLE;
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign out_left  = r_out_l;
   assign out_right = r_out_r;
   assign out_valid = r_out_valid;
   assign fading    = r_fading;

endmodule

// File: doc/audio_xfade_selector.md
Name: audio_xfade_selector

Overview:
- Next-generation source selector for the stereo 24-bit audio path. It picks one of NUM_SRC stereo sources (clean, noise, tone, ...) instead of a hard 2:1 switch.
- On a source change it performs a click-free linear crossfade over 2^RAMP_SHIFT audio samples.
- Sits between the sample generators/filters and the audio codec serializer; advances only on the codec sample strobe.

Parameters:
- WIDTH, 24, sample width in bits (two's complement).
- NUM_SRC, 4, number of selectable stereo sources (>=2).
- RAMP_SHIFT, 8, log2 of crossfade length in samples (1..12).
- SEL_W, $clog2(NUM_SRC), width of the select input (derived; not to be overridden).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe, one per audio sample period.
- src_left  in  NUM_SRC*WIDTH  left samples, source i at bits [i*WIDTH +: WIDTH].
- src_right  in  NUM_SRC*WIDTH  right samples, same packing.
- sel  in  SEL_W  requested source index.
- fade_bypass  in  1  1 = switch instantly, no ramp.
- out_left  out  WIDTH  mixed left sample (registered).
- out_right  out  WIDTH  mixed right sample (registered).
- out_valid  out  1  one-cycle strobe, output updated this cycle.
- fading  out  1  high while a crossfade is in progress.

Behaviour:
- Reset (async assert, sync release): out_left=out_right=0, out_valid=0, fading=0, cur_src=0, tgt_src=0, k=0, state IDLE.
- All state advances only in cycles with sample_valid=1. Inputs (src_*, sel, fade_bypass) are sampled in that cycle.
- Latency: out_* and out_valid=1 appear 1 clk after the sample_valid cycle. out_valid stays low otherwise.
- States:
  - IDLE: out = src[cur_src].
  - FADE: out = (src[cur_src]*(2^RAMP_SHIFT-k) + src[tgt_src]*k) >>> RAMP_SHIFT, per channel.
- IDLE, sel valid (< NUM_SRC), sel != cur_src, fade_bypass=0:
  - tgt_src<=sel, k<=0, go to FADE.
  - That tick still outputs src[cur_src].
- IDLE, same conditions but fade_bypass=1: cur_src<=sel and the same tick outputs src[sel]. No FADE.
- FADE, each tick: k increments first, then the output uses the new k.
  - When the new k = 2^RAMP_SHIFT, the output equals src[tgt_src] exactly, cur_src<=tgt_src, and the state returns to IDLE.
  - A full fade therefore spans 2^RAMP_SHIFT ticks after the detection tick.
- sel change during FADE: ignored until the fade completes; re-evaluated at the next IDLE tick, which may start a new fade. fade_bypass=1 during FADE: the fade completes at that tick (output src[tgt_src], go to IDLE).
- sel >= NUM_SRC (non-power-of-2 NUM_SRC): ignored, state unchanged.
- fading = (state == FADE), registered with the outputs.
- Arithmetic:
  - Signed products are WIDTH+RAMP_SHIFT+1 bits; the sum is WIDTH+RAMP_SHIFT+2 bits.
  - Arithmetic right shift (floor). The weights sum to 2^RAMP_SHIFT, so the result always fits WIDTH bits with no saturation needed.
- Reset asserted mid-fade: immediate return to reset values. After release the first tick compares sel against source 0.

Decomposition:
- Shared include audio_pkg.vh: AUDIO_W=24 and the state encodings (ST_IDLE, ST_FADE).
- Sub-module xfade_mac: combinational per-channel weighted mix of two WIDTH inputs with a weight k. Instantiated twice, left and right.
- Top holds the FSM, the counter, source demux and output registers.

Test Plan (WIDTH=24, NUM_SRC=4, RAMP_SHIFT=2, constant sources src0=+1048576, src1=-1048576, src2=+4096, src3=0 on both channels):
- Reset then sel=0, 3 ticks -> out=1048576 each tick, out_valid 1 clk after each strobe, fading=0; outputs 0 during reset.
- sel 0->1 -> tick outputs 1048576, 524288, 0, -524288, -1048576; fading high for the last 4 ticks, low afterwards.
- sel 1->2 with fade_bypass=1 -> the same tick outputs 4096, fading stays 0.
- During the 0->1 fade at k=2, set sel=3 -> fade to 1 completes unchanged. The next tick starts a fade to 3: -1048576, -786432, -524288, -262144, 0.
- NUM_SRC=3 build with sel=3 -> output and state unchanged.
- reset_n pulsed low mid-fade (between clock edges) -> outputs 0 immediately, fading=0. After release with sel=0, output is src0 with no fade.
